// File: rtl/pe_row_feeder.sv
// Row feeder for a weight-stationary systolic row: loads one weight into the first PE,
// streams the job's activations, then drives zeros so the partial sums flush out.
module pe_row_feeder #(
  parameter int int_bits     = 13,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [int_bits-1:0] weight_in,
  input  logic [LEN_W-1:0]    num_elems,
  input  logic                s_valid,
  input  logic [int_bits-1:0] s_data,
  output logic                s_ready,
  output logic [int_bits-1:0] out_ele,
  output logic                weight_en,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WSETUP = 3'd1,
    WPULSE = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  // A zero-length drain would skip the flush entirely, so it is stretched to one cycle.
  localparam int                DrainLast = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam logic [LEN_W:0]    DrainTgt  = DrainLast[LEN_W:0];

  state_e               state_q, state_d;
  logic [int_bits-1:0]  weight_q, weight_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [int_bits-1:0]  out_ele_q, out_ele_d;
  logic                 weight_en_q, weight_en_d;
  logic                 done_q, done_d;
  logic [LEN_W:0]       cnt_inc;

  // One extra bit so a full 2^LEN_W-1 job compares without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_ele_q   <= '0;
      weight_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      weight_q    <= weight_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_ele_q   <= out_ele_d;
      weight_en_q <= weight_en_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    weight_d    = weight_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    out_ele_d   = out_ele_q;
    weight_en_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_ele_d = '0;
        if (start) begin
          weight_d  = weight_in;
          len_d     = num_elems;
          out_ele_d = weight_in;
          state_d   = WSETUP;
        end
      end
      WSETUP: begin
        // Weight has been stable on the bus for a full cycle before the strobe rises.
        out_ele_d   = weight_q;
        weight_en_d = 1'b1;
        state_d     = WPULSE;
      end
      WPULSE: begin
        out_ele_d = '0;
        cnt_d     = '0;
        state_d   = (len_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (s_valid) begin
          out_ele_d = s_data;
          cnt_d     = cnt_inc[LEN_W-1:0];
          if (cnt_inc == {1'b0, len_q}) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end else begin
          out_ele_d = '0;
        end
      end
      DRAIN: begin
        out_ele_d = '0;
        cnt_d     = cnt_inc[LEN_W-1:0];
        if (cnt_inc == DrainTgt) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        out_ele_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register only; s_ready never looks at s_valid.
  always_comb begin
    busy    = (state_q != IDLE);
    s_ready = (state_q == STREAM);
  end

  assign out_ele   = out_ele_q;
  assign weight_en = weight_en_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder: per-cycle expected outputs go through a scoreboard queue
// and are checked #1 after each rising edge.
module tb_pe_row_feeder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] weight_in;
  logic [7:0]  num_elems;
  logic        s_valid;
  logic [12:0] s_data;
  logic        s_ready;
  logic [12:0] out_ele;
  logic        weight_en;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [12:0] out_ele;
    logic        wen;
    logic        done;
    logic        busy;
    logic        rdy;
  } obs_t;

  obs_t  sb[$];
  int    n_cmp   = 0;
  int    n_bad   = 0;
  int    accepts = 0;
  int    step    = 0;
  string phase   = "reset";

  pe_row_feeder #(.int_bits(13), .LEN_W(8), .DRAIN_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .weight_in (weight_in),
    .num_elems (num_elems),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .out_ele   (out_ele),
    .weight_en (weight_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare();
    obs_t e;
    obs_t o;
    e = sb.pop_front();
    o = '{out_ele, weight_en, done, busy, s_ready};
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s[%0d]: observed out=%0d wen=%b done=%b busy=%b rdy=%b, expected out=%0d wen=%b done=%b busy=%b rdy=%b",
             phase, step, o.out_ele, o.wen, o.done, o.busy, o.rdy,
             e.out_ele, e.wen, e.done, e.busy, e.rdy);
    end
    step++;
  endtask

  // Check the outputs right now, without waiting for a clock edge.
  task automatic expect_now(input logic [12:0] e_out, input logic e_wen, input logic e_done,
                            input logic e_busy, input logic e_rdy);
    sb.push_back('{e_out, e_wen, e_done, e_busy, e_rdy});
    compare();
  endtask

  // Drive inputs for the next edge, queue what the outputs must be after it, then check.
  task automatic tick(input logic st, input logic [12:0] wi, input logic [7:0] ne,
                      input logic sv, input logic [12:0] sd,
                      input logic [12:0] e_out, input logic e_wen, input logic e_done,
                      input logic e_busy, input logic e_rdy);
    start     = st;
    weight_in = wi;
    num_elems = ne;
    s_valid   = sv;
    s_data    = sd;
    sb.push_back('{e_out, e_wen, e_done, e_busy, e_rdy});
    #1;
    if (s_valid && s_ready) accepts++;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_accepts(input int exp_n);
    n_cmp++;
    assert (accepts === exp_n) else begin
      n_bad++;
      $error("FAIL %s accepts: observed %0d, expected %0d", phase, accepts, exp_n);
    end
    accepts = 0;
  endtask

  task automatic new_phase(input string name);
    phase   = name;
    step    = 0;
    accepts = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; weight_in = '0; num_elems = '0; s_valid = 1'b0; s_data = '0;
    #3;
    expect_now(13'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    new_phase("idle");
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // w=7, n=3, s_valid held high; weight_in changes after capture must not matter.
    new_phase("basic");
    tick(1, 7, 3, 1, 0,  7, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  7, 1, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1,  1, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 2,  2, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 3,  3, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    check_accepts(3);

    // Same job with a bubble on the second beat.
    new_phase("bubble");
    tick(1, 7, 3, 0, 0,  7, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  7, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1,  1, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 5,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 2,  2, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 3,  3, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    check_accepts(3);

    // Zero-length job: weight pulse, straight to drain, s_ready never high.
    new_phase("zero_len");
    tick(1, 5, 0, 1, 13'h77,  5, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 13'h77,  5, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 13'h77,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 13'h77,  0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    check_accepts(0);

    // start while busy is ignored; start in the done cycle begins the next job at once.
    new_phase("start_busy");
    tick(1, 4, 2, 0, 0,  4, 0, 0, 1, 0);
    tick(1, 9, 5, 0, 0,  4, 1, 0, 1, 0);
    tick(1, 9, 5, 0, 0,  0, 0, 0, 1, 1);
    tick(1, 9, 5, 1, 11, 11, 0, 0, 1, 1);
    tick(1, 9, 5, 1, 12, 12, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    check_accepts(2);
    tick(1, 9, 1, 0, 0,  9, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  9, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 13'h1FFF,  13'h1FFF, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    check_accepts(1);

    // Reset while weight_en is high.
    new_phase("rst_wpulse");
    tick(1, 6, 3, 0, 0,  6, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  6, 1, 0, 1, 0);
    #2 reset = 1'b1;
    #1 expect_now(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    expect_now(0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Reset mid-stream.
    new_phase("rst_stream");
    tick(1, 8, 3, 1, 0,  8, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  8, 1, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 21, 21, 0, 0, 1, 1);
    #2 reset = 1'b1;
    #1 expect_now(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Clean job after the aborts.
    new_phase("clean");
    tick(1, 3, 2, 1, 0,  3, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0,  3, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 31, 31, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 32, 32, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    check_accepts(2);

    // Maximum job length: 255 elements with no counter wrap.
    new_phase("max_len");
    tick(1, 2, 8'd255, 0, 0,  2, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  2, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    for (int i = 1; i <= 255; i++) begin
      tick(0, 0, 0, 1, 13'(i),  13'(i), 0, 0, 1, (i < 255));
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    check_accepts(255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
